// File: rtl/clint_rtc_tick.sv
// clint_rtc_tick: programmable RTC tick source with CLINT-style bus registers and a 64-bit tick counter.
// Define RTC_EXT_EN to take ticks from a synchronised external rt_clk instead of the phase accumulator.
module clint_rtc_tick #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ACC_W = 32,
    parameter logic [ACC_W-1:0] INC_RESET = ACC_W'(32'd1407375)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
`ifdef RTC_EXT_EN
    input  logic                rt_clk,
`endif
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                tick
);
    logic              wr, rd, clr;
    logic [1:0]        sel;
    logic              enable_q, enable_d, tick_q, tick_d, ready_q;
    logic [63:0]       cnt_q, cnt_d;
    logic [31:0]       hi_snap_q, hi_snap_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, inc_rd;
    logic              unused_bits;

    assign sel = address[3:2];
    assign wr  = valid & (&wstrb);
    assign rd  = valid & ~(|wstrb);
    assign clr = wr & (sel == 2'd0) & wdata[1];

`ifdef RTC_EXT_EN
    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    assign inc_rd      = '0;
    assign unused_bits = ^{address[ADDR_W-1:4], address[1:0], wdata[DATA_W-1:2]};
    always_comb begin
        sync_d = clr ? 2'b00 : {sync_q[0], rt_clk};
        prev_d = clr ? 1'b0 : sync_q[1];
        tick_d = ~clr & enable_q & sync_q[1] & ~prev_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end
`else
    logic [ACC_W-1:0] inc_q, inc_d, acc_q, acc_d, sum;
    logic             carry;
    assign inc_rd      = DATA_W'(inc_q);
    assign unused_bits = ^{address[ADDR_W-1:4], address[1:0]};
    // Carry out of the accumulator is the tick request; it is registered into tick.
    assign {carry, sum} = {1'b0, acc_q} + {1'b0, inc_q};
    always_comb begin
        inc_d  = (wr && sel == 2'd1) ? wdata[ACC_W-1:0] : inc_q;
        acc_d  = clr ? '0 : enable_q ? sum : acc_q;
        tick_d = ~clr & enable_q & carry;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_q <= INC_RESET;
            acc_q <= '0;
        end else begin
            inc_q <= inc_d;
            acc_q <= acc_d;
        end
    end
`endif

    // CNT_LO read snapshots the upper half so a following CNT_HI read is coherent.
    always_comb begin
        enable_d  = (wr && sel == 2'd0) ? wdata[0] : enable_q;
        cnt_d     = clr ? 64'd0 : cnt_q + 64'(tick_q);
        hi_snap_d = (rd && sel == 2'd2) ? cnt_q[63:32] : hi_snap_q;
        rdata_d   = !rd ? rdata_q :
                    sel == 2'd0 ? DATA_W'(enable_q) :
                    sel == 2'd1 ? inc_rd :
                    sel == 2'd2 ? DATA_W'(cnt_q[31:0]) : DATA_W'(hi_snap_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q  <= 1'b1;
            tick_q    <= 1'b0;
            ready_q   <= 1'b0;
            cnt_q     <= 64'd0;
            hi_snap_q <= 32'd0;
            rdata_q   <= '0;
        end else begin
            enable_q  <= enable_d;
            tick_q    <= tick_d;
            ready_q   <= valid;
            cnt_q     <= cnt_d;
            hi_snap_q <= hi_snap_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign tick  = tick_q;
endmodule

// File: tb/tb_clint_rtc_tick.sv
// tb_clint_rtc_tick: randomized and directed checks of clint_rtc_tick against a cycle-level arithmetic model.
module tb_clint_rtc_tick;
    logic        clk = 1'b0;
    logic        reset, valid;
    logic [31:0] address, wdata, rdata;
    logic [3:0]  wstrb;
    logic        ready, tick;
    int          checks = 0, failures = 0;

    logic            m_en, m_tick, m_rdy;
    logic [31:0]     m_inc, m_hi, m_rd;
    longint unsigned m_acc;
    logic [63:0]     m_cnt;

    always #5 clk = ~clk;

    clint_rtc_tick dut (
        .clk(clk), .reset(reset), .valid(valid), .address(address),
        .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready), .tick(tick)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 1'b1; m_inc = 32'd1407375; m_acc = 0; m_cnt = 0;
        m_hi = 0; m_rd = 0; m_tick = 0; m_rdy = 0;
    endtask

    task automatic model_step();
        bit wr, rd;
        int r;
        longint unsigned s;
        wr = valid && wstrb == 4'hF;
        rd = valid && wstrb == 4'h0;
        r  = int'(address[3:2]);
        m_rdy = valid;
        if (rd) begin
            if (r == 0) m_rd = 32'(m_en);
            else if (r == 1) m_rd = m_inc;
            else if (r == 2) begin m_rd = m_cnt[31:0]; m_hi = m_cnt[63:32]; end
            else m_rd = m_hi;
        end
        m_cnt = m_cnt + 64'(m_tick);
        if (wr && r == 0 && wdata[1]) begin
            m_acc = 0; m_cnt = 0; m_tick = 0;
        end else if (m_en) begin
            s = m_acc + longint'(m_inc);
            m_tick = s >= 64'h1_0000_0000;
            m_acc  = s % 64'h1_0000_0000;
        end else m_tick = 0;
        if (wr && r == 0) m_en = wdata[0];
        if (wr && r == 1) m_inc = wdata;
    endtask

    task automatic step(output logic t);
        @(posedge clk);
        model_step();
        #1;
        chk("ready", 64'(ready), 64'(m_rdy));
        chk("tick", 64'(tick), 64'(m_tick));
        chk("rdata", 64'(rdata), 64'(m_rd));
        t = tick;
        @(negedge clk);
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        logic t;
        valid = 1'b1; address = a; wdata = wd; wstrb = ws;
        step(t);
        valid = 1'b0; wstrb = 4'h0;
    endtask

    task automatic idle(input int n, output int ticks);
        logic t;
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            step(t);
            ticks += int'(t);
        end
    endtask

    initial begin
        int n;
        logic t;
        reset = 1'b1; valid = 1'b0; address = 0; wdata = 0; wstrb = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_tick", 64'(tick), 0);
        chk("rst_ready", 64'(ready), 0);
        chk("rst_rdata", 64'(rdata), 0);
        reset = 1'b0;
        bus(32'h4, 0, 4'h0);
        chk("inc_reset", 64'(rdata), 64'd1407375);
        bus(32'h0, 0, 4'h0);
        chk("ctrl_reset", 64'(rdata), 64'd1);
        // Half-rate ticking
        bus(32'h4, 32'h8000_0000, 4'hF);
        idle(100, n);
        chk("half_rate", 64'(n >= 49 && n <= 51), 1);
        bus(32'h8, 0, 4'h0);
        // Default-rate ticking from a cleared accumulator
        bus(32'h4, 32'd1407375, 4'hF);
        bus(32'h0, 32'h3, 4'hF);
        idle(20000, n);
        chk("rate", 64'(n >= 6 && n <= 7), 1);
        // Partial strobe must not write
        bus(32'h4, 32'h1234, 4'b0011);
        bus(32'h4, 0, 4'h0);
        chk("partial_wr", 64'(rdata), 64'd1407375);
        // Clear while a tick is due
        bus(32'h4, 32'hFFFF_FFFF, 4'hF);
        idle(5, n);
        bus(32'h0, 32'h3, 4'hF);
        chk("clr_tick", 64'(tick), 0);
        bus(32'h8, 0, 4'h0);
        bus(32'h0, 32'h0, 4'hF);
        idle(4, n);
        chk("disabled", 64'(n), 0);
        bus(32'h0, 32'h1, 4'hF);
        // Low-word carry and 64-bit wrap with LO/HI snapshot reads
        force dut.cnt_q = 64'h0000_0000_FFFF_FFFD;
        #1 release dut.cnt_q;
        m_cnt = 64'h0000_0000_FFFF_FFFD;
        for (int i = 0; i < 6; i++) begin
            bus(32'h8, 0, 4'h0);
            bus(32'hC, 0, 4'h0);
        end
        force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFD;
        #1 release dut.cnt_q;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFD;
        idle(10, n);
        bus(32'h8, 0, 4'h0);
        bus(32'hC, 0, 4'h0);
        chk("wrap_hi", 64'(rdata), 0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int k;
            valid   = 1'($urandom);
            address = {$urandom_range(0, 255), 2'($urandom), 2'b00} ;
            wdata   = $urandom;
            k       = $urandom_range(0, 3);
            wstrb   = k == 0 ? 4'hF : k == 1 ? 4'($urandom) : 4'h0;
            if (address[3:2] == 2'd0) wdata[1:0] = {($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)};
            step(t);
        end
        valid = 1'b0; wstrb = 4'h0;
        // Asynchronous reset with a response pending
        bus(32'h4, 32'hFFFF_FFFF, 4'hF);
        bus(32'h0, 32'h1, 4'hF);
        idle(5, n);
        valid = 1'b1; address = 32'h8; wstrb = 4'h0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_tick", 64'(tick), 0);
        chk("arst_ready", 64'(ready), 0);
        chk("arst_rdata", 64'(rdata), 0);
        @(negedge clk);
        reset = 1'b0; valid = 1'b0;
        model_reset();
        bus(32'h8, 0, 4'h0);
        chk("arst_cnt", 64'(rdata), 0);
        idle(20, n);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
